count_arbiter: RTL and testbench
================================

# count_arbiter

Controller that shares one 4-bit ripple-carry counter datapath (the fourBitCounter: 4-bit RCA incrementer, hold/increment mux, resettable D flip-flops) between two requesters. Each requester asks for a counting run of 0..15 increments. The block arbitrates round-robin, clears the counter, and holds the counter's `count` enable for exactly the requested number of cycles. It then pulses `done` to the granted requester, with the final value still on the counter output. It sits between the requesting logic and the counter instance, and is the only driver of the counter's `count` and `reset` inputs.

## Interface
- No parameters; all widths fixed at 4 bits to match the counter.
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- req0  in  1  requester 0 run request; level, held until done0 or abort
- len0  in  4  requester 0 run length (increments); sampled only at grant
- req1  in  1  requester 1 run request
- len1  in  4  requester 1 run length
- ctr_val  in  4  counter output `out`
- gnt0  out  1  requester 0 owns the counter
- gnt1  out  1  requester 1 owns the counter
- done0  out  1  one-cycle pulse: requester 0 run complete
- done1  out  1  one-cycle pulse: requester 1 run complete
- busy  out  1  a run is in progress (any state other than IDLE)
- count  out  1  drives the counter's `count` (1 = increment)
- ctr_clr_n  out  1  drives the counter's active-low `reset`

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE. All outputs decode from registered state, owner, and len_q. There are no combinational input-to-output paths.
- IDLE: outputs gnt, done, busy and count are 0; ctr_clr_n is 1.
  - If only one req is high, that requester wins.
  - If both are high, the requester not served last wins.
  - On a win: latch owner and len_q, update the last-served pointer, go to CLEAR.
- Last-served pointer resets to requester 1, so requester 0 wins the first tie.
- CLEAR (one cycle): gnt_owner=1, busy=1, ctr_clr_n=0, count=0.
  - len_q==0: next state DONE.
  - Otherwise: next state RUN.
- RUN: gnt_owner=1, busy=1, count=1, ctr_clr_n=1.
  - Stays for exactly len_q cycles.
  - Exits to DONE on the cycle where ctr_val == len_q-1.
- DONE (one cycle): gnt_owner=1, done_owner=1, busy=1, count=0. ctr_val equals len_q. Next state IDLE.
- Abort: if the owner's req drops in CLEAR or RUN, go to IDLE next edge.
  - No done pulse.
  - count drops with the state change.
  - Counter keeps its partial value.
- req of the owner during DONE is ignored; the next state is IDLE regardless.
- len inputs are ignored except in the granting IDLE cycle. Changing len mid-run has no effect.
- At most one of gnt0/gnt1 is high at any time. done_x implies gnt_x.
- No wrap-around is possible: len_q ≤ 15 and the counter starts at 0, so the counter never exceeds 15.

## Timing
- Reset (asynchronous, any state, including mid-run):
  - State goes to IDLE immediately and the pointer goes to requester 1.
  - gnt0/gnt1/done0/done1/busy/count = 0; ctr_clr_n = 1.
  - The counter shares the system reset, so it also clears.
- Request seen in IDLE at cycle 0:
  - CLEAR at cycle 1.
  - RUN at cycles 2..len+1, with ctr_val = k-2 in cycle k.
  - DONE at cycle len+2, with ctr_val = len.
  - IDLE at cycle len+3.
- Total occupancy is len+3 cycles; len=0 takes 3 cycles (IDLE→CLEAR→DONE→IDLE).
- A waiting requester can be accepted in the IDLE cycle right after DONE. Minimum gap between runs is one IDLE cycle.
- Latency from req to gnt: 1 cycle when uncontested.

## Test plan
- Reset: hold reset=0 → all outputs 0 except ctr_clr_n=1. Release, then req0=1, len0=5 → gnt0 at cycle 1, count high for exactly 5 cycles, done0 at cycle 7 with ctr_val=5, busy low at cycle 8.
- Zero length: req1=1, len1=0 → CLEAR then DONE, count never high, done1 with ctr_val=0.
- Max length and tie: req0=req1=1, len0=15, len1=3.
  - After reset, requester 0 is served first: done0 with ctr_val=15, no wrap.
  - Requester 1 is then granted in the next IDLE cycle: done1 with ctr_val=3.
  - Both requesters re-requesting alternates the grants.
- Abort: req0 with len0=10; drop req0 after 4 RUN cycles → count low on the next cycle, no done0, ctr_val=4 (or 5 if the drop lands on the edge), IDLE.
- Mid-run reset: assert reset during RUN of len=8 → asynchronous return to all-zero outputs. After release, a new req1 with len1=2 completes normally with ctr_val=2.
- Len stability: change len0 from 6 to 2 during RUN → run still completes at ctr_val=6.

Source files
------------

// File: rtl/count_arbiter.sv
// Round-robin owner of a shared 4-bit counter: clears it, then enables
// counting for the granted run length and pulses done to the owner.
module count_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic [3:0] len0,
    input  logic       req1,
    input  logic [3:0] len1,
    input  logic [3:0] ctr_val,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       busy,
    output logic       count,
    output logic       ctr_clr_n
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_e;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [3:0] len_q, len_d;
    logic       own_req;

    assign own_req = owner_q ? req1 : req0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            len_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        len_d   = len_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester not served last wins
                    owner_d = (req0 && req1) ? ~last_q : req1;
                    len_d   = owner_d ? len1 : len0;
                    last_d  = owner_d;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (!own_req) begin
                    state_d = IDLE;
                end else if (len_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!own_req) begin
                    state_d = IDLE;
                end else if (ctr_val == len_q - 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign gnt0      = busy && !owner_q;
    assign gnt1      = busy && owner_q;
    assign done0     = (state_q == DONE) && !owner_q;
    assign done1     = (state_q == DONE) && owner_q;
    assign count     = (state_q == RUN);
    assign ctr_clr_n = (state_q != CLEAR);

endmodule

// File: tb/tb_count_arbiter.sv
// Bench for count_arbiter: counter model, cycle-offset reference model,
// per-cycle compare and directed scenarios with literal expectations.
module tb_count_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [3:0] len0 = 4'd0;
    logic [3:0] len1 = 4'd0;
    logic [3:0] ctr_val;
    logic       gnt0, gnt1, done0, done1, busy, count, ctr_clr_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    count_arbiter dut (
        .clock(clock),
        .reset(reset),
        .req0(req0),
        .len0(len0),
        .req1(req1),
        .len1(len1),
        .ctr_val(ctr_val),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .done0(done0),
        .done1(done1),
        .busy(busy),
        .count(count),
        .ctr_clr_n(ctr_clr_n)
    );

    // The shared counter: async clear from system reset or ctr_clr_n
    logic       crst_n;
    logic [3:0] ctr_q = 4'd0;
    assign crst_n  = reset & ctr_clr_n;
    assign ctr_val = ctr_q;
    always @(posedge clock or negedge crst_n) begin
        if (!crst_n) ctr_q <= 4'd0;
        else if (count) ctr_q <= ctr_q + 4'd1;
    end

    // Reference: a run is a cycle offset t from grant; t=1 clear,
    // t=2..len+1 counting, t=len+2 done
    bit m_act  = 1'b0;
    bit m_own  = 1'b0;
    bit m_last = 1'b1;
    int m_len  = 0;
    int m_t    = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_act = 1'b0; m_own = 1'b0; m_last = 1'b1;
            m_len = 0; m_t = 0;
        end else if (!m_act) begin
            if (req0 || req1) begin
                m_own  = (req0 && req1) ? !m_last : req1;
                m_len  = m_own ? int'(len1) : int'(len0);
                m_last = m_own;
                m_act  = 1'b1;
                m_t    = 1;
            end
        end else if (m_t == m_len + 2) begin
            m_act = 1'b0;
        end else if (!(m_own ? req1 : req0)) begin
            m_act = 1'b0;
        end else begin
            m_t++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        bit e_done;
        e_done = m_act && (m_t == m_len + 2);
        chk("busy", busy, m_act);
        chk("gnt0", gnt0, m_act && !m_own);
        chk("gnt1", gnt1, m_act && m_own);
        chk("done0", done0, e_done && !m_own);
        chk("done1", done1, e_done && m_own);
        chk("count", count, m_act && m_t >= 2 && m_t <= m_len + 1);
        chk("ctr_clr_n", ctr_clr_n, !(m_act && m_t == 1));
        if (e_done) chk("done_val", ctr_val, m_len);
    end

    task automatic run(input bit who, input int len, input int new_len,
                       input int chg_at, output int hi, output int dc,
                       output int dv);
        hi = 0; dc = -1; dv = -1;
        if (who) begin req1 = 1'b1; len1 = 4'(len); end
        else begin req0 = 1'b1; len0 = 4'(len); end
        for (int c = 1; c <= 40 && dc < 0; c++) begin
            @(negedge clock);
            if (c == chg_at) begin
                if (who) len1 = 4'(new_len);
                else len0 = 4'(new_len);
            end
            if (count) hi++;
            if (who ? done1 : done0) begin
                dc = c;
                dv = int'(ctr_val);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    int hi, dc, dv, first, nd;
    int dcyc[4], down[4], dval[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt0 | gnt1, 0);
        chk("rst_done", done0 | done1, 0);
        chk("rst_count", count, 0);
        chk("rst_clr_n", ctr_clr_n, 1);
        reset = 1'b1;
        @(negedge clock);

        run(1'b0, 5, 5, 0, hi, dc, dv);
        chk("t1_count_cycles", hi, 5);
        chk("t1_done_cycle", dc, 7);
        chk("t1_done_val", dv, 5);
        @(negedge clock);
        chk("t1_busy_after", busy, 0);

        run(1'b1, 0, 0, 0, hi, dc, dv);
        chk("t2_count_cycles", hi, 0);
        chk("t2_done_cycle", dc, 2);
        chk("t2_done_val", dv, 0);
        @(negedge clock);

        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        req0 = 1'b1; len0 = 4'd15;
        req1 = 1'b1; len1 = 4'd3;
        first = -1; nd = 0;
        for (int c = 1; c <= 80 && nd < 4; c++) begin
            @(negedge clock);
            if (first < 0 && gnt0) first = 0;
            else if (first < 0 && gnt1) first = 1;
            if (done0 || done1) begin
                dcyc[nd] = c;
                down[nd] = done1 ? 1 : 0;
                dval[nd] = int'(ctr_val);
                nd++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("t3_first_gnt", first, 0);
        chk("t3_n_done", nd, 4);
        chk("t3_d0_cyc", dcyc[0], 17);
        chk("t3_d0_own", down[0], 0);
        chk("t3_d0_val", dval[0], 15);
        chk("t3_d1_cyc", dcyc[1], 23);
        chk("t3_d1_own", down[1], 1);
        chk("t3_d1_val", dval[1], 3);
        chk("t3_d2_cyc", dcyc[2], 41);
        chk("t3_d2_own", down[2], 0);
        chk("t3_d3_cyc", dcyc[3], 47);
        chk("t3_d3_own", down[3], 1);
        @(negedge clock);
        chk("t3_busy_after", busy, 0);

        req0 = 1'b1; len0 = 4'd10;
        hi = 0; nd = 0;
        for (int c = 1; c <= 20 && req0; c++) begin
            @(negedge clock);
            if (count) hi++;
            if (done0) nd++;
            if (hi == 4) req0 = 1'b0;
        end
        @(negedge clock);
        chk("t4_count_low", count, 0);
        chk("t4_busy_low", busy, 0);
        chk("t4_ctr_val", ctr_val, 4);
        repeat (3) @(negedge clock);
        chk("t4_ctr_hold", ctr_val, 4);
        chk("t4_no_done", nd, 0);

        req0 = 1'b1; len0 = 4'd8;
        repeat (4) @(negedge clock);
        chk("t5_in_run", count, 1);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_count", count, 0);
        chk("t5_rst_gnt", gnt0 | gnt1, 0);
        chk("t5_rst_clr_n", ctr_clr_n, 1);
        chk("t5_rst_ctr", ctr_val, 0);
        req0 = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        run(1'b1, 2, 2, 0, hi, dc, dv);
        chk("t5_done_cycle", dc, 4);
        chk("t5_done_val", dv, 2);
        @(negedge clock);

        run(1'b0, 6, 2, 3, hi, dc, dv);
        chk("t6_count_cycles", hi, 6);
        chk("t6_done_cycle", dc, 8);
        chk("t6_done_val", dv, 6);
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
